imm_decode: RTL and testbench

Pipelined immediate-extraction stage that sits directly upstream of the sign extender in the instruction-decode path. It accepts 32-bit RV32I instruction words over a valid/ready handshake, identifies the immediate format (I, S, B), and assembles the raw 12-bit immediate field. It also produces the 32-bit sign-extended immediate that the downstream `sign_ext`/`neg` logic consumes. A 2-entry output buffer gives full throughput under backpressure, and a saturating counter tracks unsupported opcodes.

---
 rtl/imm_decode_if.sv | 26 ++
 rtl/imm_decode.sv | 127 ++++++++++++
 tb/tb_imm_decode.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_decode_if.sv
// Valid/ready handshake bundle for the immediate-extraction stage.
// The master drives instruction words in and accepts decoded results.
interface imm_decode_if #(
    parameter int ILL_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          in_instr;
    logic                 out_valid;
    logic                 out_ready;
    logic [1:0]           out_fmt;
    logic [11:0]          out_imm;
    logic [31:0]          out_ext_imm;
    logic                 out_illegal;
    logic [ILL_CNT_W-1:0] ill_cnt;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_fmt, out_imm, out_ext_imm, out_illegal, ill_cnt
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_fmt, out_imm, out_ext_imm, out_illegal, ill_cnt
    );
endinterface

// File: rtl/imm_decode.sv
// RV32I I/S/B immediate extraction with a 2-entry output buffer and a
// saturating count of unsupported opcodes.
module imm_decode #(
    parameter int ILL_CNT_W = 8
) (
    input logic         clk,
    input logic         rst_n,
    imm_decode_if.slave bus
);
    typedef enum logic [1:0] {
        FMT_ILLEGAL = 2'd0,
        FMT_I       = 2'd1,
        FMT_S       = 2'd2,
        FMT_B       = 2'd3
    } fmt_e;

    typedef struct packed {
        fmt_e        fmt;
        logic [11:0] imm;
        logic [31:0] ext_imm;
        logic        illegal;
    } entry_t;

    entry_t               dec;
    entry_t               head_q, head_d;
    entry_t               skid_q, skid_d;
    logic [1:0]           count_q, count_d;
    logic                 in_ready_q, in_ready_d;
    logic [ILL_CNT_W-1:0] ill_cnt_q, ill_cnt_d;
    logic                 push, pop;
    logic [31:0]          instr;
    logic                 unused_instr_bits;

    assign instr             = bus.in_instr;
    assign unused_instr_bits = ^instr[19:12];

    // Format decode feeds only the buffer registers, never the outputs directly.
    always_comb begin
        dec = '0;
        unique case (instr[6:0])
            7'b0000011, 7'b0010011, 7'b1100111: begin
                dec.fmt     = FMT_I;
                dec.imm     = instr[31:20];
                dec.ext_imm = {{20{instr[31]}}, instr[31:20]};
            end
            7'b0100011: begin
                dec.fmt     = FMT_S;
                dec.imm     = {instr[31:25], instr[11:7]};
                dec.ext_imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            7'b1100011: begin
                dec.fmt     = FMT_B;
                dec.imm     = {instr[31], instr[7], instr[30:25], instr[11:8]};
                dec.ext_imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                               instr[11:8], 1'b0};
            end
            default: dec.illegal = 1'b1;
        endcase
    end

    assign push = bus.in_valid && in_ready_q;
    assign pop  = (count_q != 2'd0) && bus.out_ready;

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
        head_d    = head_q;
        skid_d    = skid_q;
        count_d   = count_q;
        ill_cnt_d = ill_cnt_q;
        unique case (count_q)
            2'd0: begin
                if (push) begin
                    head_d  = dec;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    head_d = dec;
                end else if (push) begin
                    skid_d  = dec;
                    count_d = 2'd2;
                end else if (pop) begin
                    count_d = 2'd0;
                end
            end
            default: begin
                // Full: in_ready_q is low, so only a dequeue can happen here.
                if (pop) begin
                    head_d  = skid_q;
                    count_d = 2'd1;
                end
            end
        endcase
        if (push && dec.illegal && (ill_cnt_q != '1)) begin
            ill_cnt_d = ill_cnt_q + ILL_CNT_W'(1);
        end
        // Registered from next occupancy, so out_ready never reaches in_ready combinationally.
        in_ready_d = (count_d != 2'd2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: payload registers are reset too, because the outputs must read zero out of reset.
            head_q     <= '0;
            skid_q     <= '0;
            count_q    <= 2'd0;
            in_ready_q <= 1'b0;
            ill_cnt_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            head_q     <= head_d;
            skid_q     <= skid_d;
            count_q    <= count_d;
            in_ready_q <= in_ready_d;
            ill_cnt_q  <= ill_cnt_d;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = (count_q != 2'd0);
    assign bus.out_fmt     = head_q.fmt;
    assign bus.out_imm     = head_q.imm;
    assign bus.out_ext_imm = head_q.ext_imm;
    assign bus.out_illegal = head_q.illegal;
    assign bus.ill_cnt     = ill_cnt_q;
endmodule

// File: tb/tb_imm_decode.sv
// Scenario bench for imm_decode: each task drives one feature and checks it;
// a negedge monitor scores every delivered word against a reference queue.
module tb_imm_decode;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   tests_run = 0;
    int   tests_failed = 0;
    logic rand_done;

    logic [46:0] sb[$];

    imm_decode_if #(.ILL_CNT_W(8)) bus ();

    imm_decode #(.ILL_CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [46:0] model(input logic [31:0] w);
        logic [11:0] imm;
        logic [31:0] ext;
        logic [1:0]  fmt;
        logic        ill;
        imm = '0;
        ext = '0;
        fmt = 2'd0;
        ill = 1'b0;
        case (w[6:0])
            7'h03, 7'h13, 7'h67: begin
                fmt = 2'd1;
                imm = w[31:20];
                ext = {{20{imm[11]}}, imm};
            end
            7'h23: begin
                fmt = 2'd2;
                imm = {w[31:25], w[11:7]};
                ext = {{20{imm[11]}}, imm};
            end
            7'h63: begin
                fmt = 2'd3;
                imm = {w[31], w[7], w[30:25], w[11:8]};
                ext = {{19{imm[11]}}, imm, 1'b0};
            end
            default: ill = 1'b1;
        endcase
        return {fmt, imm, ext, ill};
    endfunction

    // Inputs and outputs are stable at negedge; transfers complete at the next posedge.
    always @(negedge clk) begin
        logic [46:0] exp_v;
        logic [46:0] act_v;
        if (rst_n) begin
            if (bus.in_valid && bus.in_ready) sb.push_back(model(bus.in_instr));
            if (bus.out_valid && bus.out_ready) begin
                tests_run++;
                act_v = {bus.out_fmt, bus.out_imm, bus.out_ext_imm, bus.out_illegal};
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_underflow: output %h delivered, none expected", act_v);
                end else begin
                    exp_v = sb.pop_front();
                    if (act_v !== exp_v) begin
                        tests_failed++;
                        $display("FAIL sb_word: got fmt/imm/ext/ill %h, expected %h", act_v, exp_v);
                    end
                end
            end
        end
    end

    task automatic send(input logic [31:0] w);
        bit done = 0;
        bus.in_valid = 1'b1;
        bus.in_instr = w;
        for (int g = 0; g < 1000 && !done; g++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        if (!done) begin
            tests_run++;
            tests_failed++;
            $display("FAIL send_timeout: in_ready got 0 for 1000 cycles, expected 1");
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0 && !bus.out_valid) break;
        end
        tests_run++;
        if (sb.size() != 0 || bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL drain: pending %0d out_valid %b, expected 0 and 0", sb.size(), bus.out_valid);
        end
    endtask

    task automatic test_reset();
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b0;
        #11;
        tests_run++;
        if ({bus.out_valid, bus.in_ready, bus.out_fmt, bus.out_imm, bus.out_ext_imm,
             bus.out_illegal, bus.ill_cnt} !== '0) begin
            tests_failed++;
            $display("FAIL reset_state: valid %b ready %b imm %h ext %h cnt %0d, expected all 0",
                     bus.out_valid, bus.in_ready, bus.out_imm, bus.out_ext_imm, bus.ill_cnt);
        end
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: in_ready %b out_valid %b, expected 1 and 0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_i_stream();
        logic [31:0] w[4]   = '{32'h00A00093, 32'hFFB00093, 32'h53900093, 32'h81D00093};
        logic [11:0] imm[4] = '{12'h00A, 12'hFFB, 12'h539, 12'h81D};
        logic [31:0] ext[4] = '{32'h0000000A, 32'hFFFFFFFB, 32'h00000539, 32'hFFFFF81D};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(w[i]);
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_imm !== imm[i] || bus.out_ext_imm !== ext[i]
                || bus.out_fmt !== 2'd1) begin
                tests_failed++;
                $display("FAIL i_stream[%0d]: valid %b fmt %0d imm %h ext %h, expected 1 1 %h %h",
                         i, bus.out_valid, bus.out_fmt, bus.out_imm, bus.out_ext_imm, imm[i], ext[i]);
            end
        end
        drain();
    endtask

    task automatic test_s_b();
        bus.out_ready = 1'b1;
        send(32'hFE20AA23);
        tests_run++;
        if (bus.out_fmt !== 2'd2 || bus.out_imm !== 12'hFF4 || bus.out_ext_imm !== 32'hFFFFFFF4) begin
            tests_failed++;
            $display("FAIL s_format: fmt %0d imm %h ext %h, expected 2 ff4 fffffff4",
                     bus.out_fmt, bus.out_imm, bus.out_ext_imm);
        end
        send(32'hFE000CE3);
        tests_run++;
        if (bus.out_fmt !== 2'd3 || bus.out_imm !== 12'hFFC || bus.out_ext_imm !== 32'hFFFFFFF8) begin
            tests_failed++;
            $display("FAIL b_format: fmt %0d imm %h ext %h, expected 3 ffc fffffff8",
                     bus.out_fmt, bus.out_imm, bus.out_ext_imm);
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [31:0] bp[5] = '{32'h12300093, 32'h45600013, 32'h78900093, 32'hABC00013, 32'h00100093};
        int idx = 0;
        bit acc;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = bp[0];
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                idx++;
                bus.in_instr = bp[idx];
            end
            tests_run++;
            if (bus.out_valid !== 1'b1 || bus.out_imm !== 12'h123 || bus.out_ext_imm !== 32'h00000123) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: valid %b imm %h ext %h, expected 1 123 00000123",
                         c, bus.out_valid, bus.out_imm, bus.out_ext_imm);
            end
        end
        bus.in_valid = 1'b0;
        tests_run++;
        if (idx != 2 || bus.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_accepts: accepted %0d in_ready %b, expected 2 and 0", idx, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.in_ready !== 1'b1 || bus.out_imm !== 12'h456) begin
            tests_failed++;
            $display("FAIL bp_release: in_ready %b imm %h, expected 1 456", bus.in_ready, bus.out_imm);
        end
        for (int i = 2; i < 5; i++) send(bp[i]);
        drain();
    endtask

    task automatic test_illegal();
        bus.out_ready = 1'b1;
        send(32'h00000033);
        tests_run++;
        if (bus.out_illegal !== 1'b1 || bus.out_fmt !== 2'd0 || bus.out_imm !== 12'h000
            || bus.out_ext_imm !== 32'h0 || bus.ill_cnt !== 8'd1) begin
            tests_failed++;
            $display("FAIL illegal_first: ill %b fmt %0d imm %h ext %h cnt %0d, expected 1 0 000 0 1",
                     bus.out_illegal, bus.out_fmt, bus.out_imm, bus.out_ext_imm, bus.ill_cnt);
        end
        for (int i = 0; i < 300; i++) begin
            send(32'h0000007F);
            if (i == 252) begin
                tests_run++;
                if (bus.ill_cnt !== 8'd254) begin
                    tests_failed++;
                    $display("FAIL ill_cnt_pre_sat: got %0d, expected 254", bus.ill_cnt);
                end
            end
        end
        drain();
        tests_run++;
        if (bus.ill_cnt !== 8'd255) begin
            tests_failed++;
            $display("FAIL ill_cnt_sat: got %0d, expected 255", bus.ill_cnt);
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        send(32'h00100093);
        send(32'h00200093);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.ill_cnt !== 8'd0 || bus.in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_async: valid %b cnt %0d in_ready %b, expected 0 0 0",
                     bus.out_valid, bus.ill_cnt, bus.in_ready);
        end
        sb.delete();
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_release: valid %b in_ready %b, expected 0 1",
                     bus.out_valid, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        send(32'h00500093);
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_imm !== 12'h005 || bus.out_ext_imm !== 32'h00000005) begin
            tests_failed++;
            $display("FAIL reset_first_word: valid %b imm %h ext %h, expected 1 005 00000005",
                     bus.out_valid, bus.out_imm, bus.out_ext_imm);
        end
        drain();
    endtask

    task automatic test_random();
        logic [6:0]  ops[6] = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h00};
        logic [31:0] r;
        logic [6:0]  op;
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        bus.in_valid = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    r  = $urandom();
                    op = ops[$urandom_range(0, 5)];
                    if (op == 7'h00) op = r[6:0];
                    send({r[31:7], op});
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();
    endtask

    initial begin
        test_reset();
        test_i_stream();
        test_s_b();
        test_backpressure();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
